shadow_slowram_ctrl: RTL and testbench

- Sits between the 65C816 bus decode in the iigs top level and the 128 KiB slow RAM (banks E0/E1).
- Detects CPU writes to fast RAM that fall in enabled shadow regions and queues them in a write buffer.
- Drains the buffer into slow RAM on 1 MHz slot pulses, then arbitrates direct CPU accesses to E0/E1.
- Stalls the CPU when the buffer is full or a direct slow access is waiting. Implements the 0x->Ex copy and slowdown mechanism.

---
 rtl/iigs_mem_pkg.sv | 58 +++++
 rtl/shadow_fifo.sv | 55 +++++
 rtl/shadow_slowram_ctrl.sv | 147 ++++++++++++++
 tb/tb_shadow_slowram_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/iigs_mem_pkg.sv
// Shared shadow-region decode, FSM state and write-buffer entry types for the IIgs slow RAM path.
package iigs_mem_pkg;

    localparam int SH_TXT  = 0;
    localparam int SH_HGR1 = 1;
    localparam int SH_HGR2 = 2;
    localparam int SH_SHR  = 3;
    localparam int SH_AUX  = 4;
    localparam int SH_ALT  = 5;
    localparam int SH_IO   = 6;

    localparam logic [15:0] TXT_BASE   = 16'h0400;
    localparam logic [15:0] TXT_LIMIT  = 16'h07FF;
    localparam logic [15:0] ALT_BASE   = 16'h0800;
    localparam logic [15:0] ALT_LIMIT  = 16'h0BFF;
    localparam logic [15:0] HGR1_BASE  = 16'h2000;
    localparam logic [15:0] HGR1_LIMIT = 16'h3FFF;
    localparam logic [15:0] HGR2_BASE  = 16'h4000;
    localparam logic [15:0] HGR2_LIMIT = 16'h5FFF;

    localparam logic [7:0] SLOW_BANK0 = 8'hE0;
    localparam logic [7:0] SLOW_BANK1 = 8'hE1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EMPTY,
        WAIT_SLOT,
        CAPTURE
    } ctrl_state_e;

    typedef struct packed {
        logic [16:0] a17;
        logic [7:0]  d8;
    } fifo_entry_t;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Shadow bits are active-low enables; aux (odd) banks are further gated by the AUX bit,
    // except that SHR shadowing forces aux hires regions on.
    function automatic logic shadow_hit(input logic aux, input logic [15:0] a,
                                        input logic [5:0] sh);
        logic hit;
        hit = 1'b0;
        if (in_range(a, TXT_BASE, TXT_LIMIT))
            hit = ~sh[SH_TXT] & (~aux | ~sh[SH_AUX]);
        else if (in_range(a, ALT_BASE, ALT_LIMIT))
            hit = ~sh[SH_ALT] & (~aux | ~sh[SH_AUX]);
        else if (in_range(a, HGR1_BASE, HGR1_LIMIT))
            hit = aux ? ((~sh[SH_HGR1] & ~sh[SH_AUX]) | ~sh[SH_SHR]) : ~sh[SH_HGR1];
        else if (in_range(a, HGR2_BASE, HGR2_LIMIT))
            hit = aux ? ((~sh[SH_HGR2] & ~sh[SH_AUX]) | ~sh[SH_SHR]) : ~sh[SH_HGR2];
        return hit;
    endfunction

endpackage

// File: rtl/shadow_fifo.sv
// Synchronous write buffer for shadowed writes; head entry is visible combinationally.
// Caller guarantees no push when full and no pop when empty.
module shadow_fifo
    import iigs_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              push_i,
    input  fifo_entry_t       push_dat_i,
    input  logic              pop_i,
    output fifo_entry_t       head_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;

    always_ff @(posedge clk_sys) begin
        if (push_i)
            mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule

// File: rtl/shadow_slowram_ctrl.sv
// Buffers shadowed fast-RAM writes into slow RAM (E0/E1) on 1 MHz slots and arbitrates
// direct CPU E0/E1 accesses behind the buffer so slow RAM sees writes in program order.
module shadow_slowram_ctrl
    import iigs_mem_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RAMSIZE = 20,
    parameter int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_strobe,
    input  logic [7:0]        bank,
    input  logic [15:0]       addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    input  logic              io,
    input  logic [7:0]        shadow,
    input  logic              shadow_all,
    input  logic              slow_slot,
    output logic [16:0]       slow_addr,
    output logic [7:0]        slow_wdata,
    output logic              slow_ce,
    output logic              slow_we,
    input  logic [7:0]        slow_rdata,
    output logic              cpu_stall,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [LVL_W-1:0]  fifo_level
);

    ctrl_state_e  state_q;
    logic [16:0]  acc_addr_q;
    logic [7:0]   acc_wdata_q;
    logic         acc_we_q;
    logic [16:0]  slow_addr_q;
    logic [7:0]   slow_wdata_q;
    logic         slow_ce_q;
    logic         slow_we_q;
    logic [7:0]   rd_data_q;
    logic         rd_valid_q;

    fifo_entry_t  push_dat;
    fifo_entry_t  head_dat;
    logic         fifo_full;
    logic         fifo_empty;
    logic         bank_ok;
    logic         hit;
    logic         push;
    logic         pop;
    logic         direct;
    logic         unused_shadow;

    assign unused_shadow = ^shadow[7:6];

    always_comb begin
        bank_ok = (bank == 8'h00) || (bank == 8'h01) ||
                  (shadow_all && ({24'd0, bank} < 32'(RAMSIZE)));
        hit     = ~io & bank_ok & shadow_hit(bank[0], addr, shadow[5:0]);
    end

    // Full is judged on the pre-edge level, so a same-cycle pop never makes room for a push.
    assign push     = cpu_strobe & we & hit & ~fifo_full;
    assign pop      = slow_slot & ~fifo_empty & (state_q != WAIT_SLOT);
    assign direct   = cpu_strobe & ~io & ((bank == SLOW_BANK0) || (bank == SLOW_BANK1));
    assign push_dat = '{a17: {bank[0], addr}, d8: wdata};

    shadow_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            acc_we_q     <= 1'b0;
            slow_addr_q  <= '0;
            slow_wdata_q <= '0;
            slow_ce_q    <= 1'b0;
            slow_we_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            slow_ce_q  <= 1'b0;
            slow_we_q  <= 1'b0;
            rd_valid_q <= 1'b0;

            if (pop) begin
                slow_ce_q    <= 1'b1;
                slow_we_q    <= 1'b1;
                slow_addr_q  <= head_dat.a17;
                slow_wdata_q <= head_dat.d8;
            end

            case (state_q)
                IDLE: begin
                    if (direct) begin
                        acc_addr_q  <= {bank[0], addr};
                        acc_wdata_q <= wdata;
                        acc_we_q    <= we;
                        state_q     <= WAIT_EMPTY;
                    end
                end
                WAIT_EMPTY: begin
                    if (fifo_empty)
                        state_q <= WAIT_SLOT;
                end
                WAIT_SLOT: begin
                    if (slow_slot) begin
                        slow_ce_q    <= 1'b1;
                        slow_we_q    <= acc_we_q;
                        slow_addr_q  <= acc_addr_q;
                        slow_wdata_q <= acc_wdata_q;
                        state_q      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rd_data_q  <= slow_rdata;
                    rd_valid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_stall  = ~reset & (fifo_full | (state_q != IDLE) | direct);
    assign slow_addr  = slow_addr_q;
    assign slow_wdata = slow_wdata_q;
    assign slow_ce    = slow_ce_q;
    assign slow_we    = slow_we_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_shadow_slowram_ctrl.sv
// Directed bench for shadow_slowram_ctrl: shadow decode, drain ordering, full stall, direct access, reset.
module tb_shadow_slowram_ctrl;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              cpu_strobe;
    logic [7:0]        bank;
    logic [15:0]       addr;
    logic [7:0]        wdata;
    logic              we;
    logic              io;
    logic [7:0]        shadow;
    logic              shadow_all;
    logic              slow_slot;
    logic [16:0]       slow_addr;
    logic [7:0]        slow_wdata;
    logic              slow_ce;
    logic              slow_we;
    logic [7:0]        slow_rdata;
    logic              cpu_stall;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [LVL_W-1:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    shadow_slowram_ctrl #(
        .DEPTH   (DEPTH),
        .RAMSIZE (20)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cpu_strobe (cpu_strobe),
        .bank       (bank),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .io         (io),
        .shadow     (shadow),
        .shadow_all (shadow_all),
        .slow_slot  (slow_slot),
        .slow_addr  (slow_addr),
        .slow_wdata (slow_wdata),
        .slow_ce    (slow_ce),
        .slow_we    (slow_we),
        .slow_rdata (slow_rdata),
        .cpu_stall  (cpu_stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_level (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wr(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
        cpu_strobe = 1'b1; we = 1'b1; io = 1'b0; bank = b; addr = a; wdata = d;
        tick();
        cpu_strobe = 1'b0; we = 1'b0;
    endtask

    task automatic slot();
        slow_slot = 1'b1;
        tick();
        slow_slot = 1'b0;
    endtask

    task automatic direct(input string tag, input logic [7:0] b, input logic [15:0] a,
                          input logic w, input logic [7:0] d);
        cpu_strobe = 1'b1; we = w; io = 1'b0; bank = b; addr = a; wdata = d;
        #1;
        chk({tag, "_stall_on_strobe"}, 32'(cpu_stall), 1);
        tick();
        cpu_strobe = 1'b0; we = 1'b0;
        chk({tag, "_stall_wait"}, 32'(cpu_stall), 1);
    endtask

    task automatic chk_drain(input string tag, input logic [16:0] a, input logic [7:0] d);
        chk({tag, "_ce"},    32'(slow_ce),    1);
        chk({tag, "_we"},    32'(slow_we),    1);
        chk({tag, "_addr"},  32'(slow_addr),  32'(a));
        chk({tag, "_wdata"}, 32'(slow_wdata), 32'(d));
    endtask

    initial begin
        reset = 1'b1; cpu_strobe = 1'b0; bank = '0; addr = '0; wdata = '0; we = 1'b0;
        io = 1'b0; shadow = 8'h00; shadow_all = 1'b0; slow_slot = 1'b0; slow_rdata = 8'h5A;
        repeat (2) tick();
        chk("rst_ce",    32'(slow_ce),    0);
        chk("rst_stall", 32'(cpu_stall),  0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_rdv",   32'(rd_valid),   0);
        chk("rst_addr",  32'(slow_addr),  0);
        reset = 1'b0;
        tick();

        // Basic text-page shadow write and drain
        wr(8'h00, 16'h0400, 8'hA5);
        chk("t1_level1", 32'(fifo_level), 1);
        repeat (2) tick();
        slot();
        chk_drain("t1", 17'h00400, 8'hA5);
        chk("t1_level0", 32'(fifo_level), 0);
        tick();
        chk("t1_ce_pulse", 32'(slow_ce), 0);

        // AUX+SHR inhibited: aux hires ignored, main hires still shadowed
        shadow = 8'h18;
        wr(8'h01, 16'h2000, 8'h11);
        chk("t2_aux_skip", 32'(fifo_level), 0);
        wr(8'h00, 16'h2000, 8'h22);
        chk("t2_main_hit", 32'(fifo_level), 1);
        slot();
        chk_drain("t2", 17'h02000, 8'h22);
        // io cycles are never shadowed
        shadow = 8'h00;
        io = 1'b1; cpu_strobe = 1'b1; we = 1'b1; bank = 8'h00; addr = 16'h0400; wdata = 8'h33;
        tick();
        cpu_strobe = 1'b0; we = 1'b0; io = 1'b0;
        chk("t2_io_skip", 32'(fifo_level), 0);

        // Fill to DEPTH, fifth write stalls until one slot drains
        for (int i = 0; i < 4; i++)
            wr(8'h00, 16'h0400 + 16'(i), 8'(i + 1));
        chk("t3_full_level", 32'(fifo_level), 4);
        chk("t3_full_stall", 32'(cpu_stall),  1);
        cpu_strobe = 1'b1; we = 1'b1; bank = 8'h00; addr = 16'h0404; wdata = 8'h05;
        #1;
        chk("t3_stall5", 32'(cpu_stall), 1);
        tick();
        chk("t3_no_push", 32'(fifo_level), 4);
        slot();
        chk_drain("t3_d0", 17'h00400, 8'h01);
        chk("t3_level3",  32'(fifo_level), 3);
        chk("t3_unstall", 32'(cpu_stall),  0);
        tick();
        cpu_strobe = 1'b0; we = 1'b0;
        chk("t3_5th_in", 32'(fifo_level), 4);
        for (int i = 1; i < 5; i++) begin
            slot();
            chk_drain($sformatf("t3_d%0d", i), 17'h00400 + 17'(i), 8'(i + 1));
        end
        chk("t3_empty", 32'(fifo_level), 0);

        // Direct read waits for two drains, then takes the next slot
        wr(8'h00, 16'h0400, 8'hAA);
        wr(8'h00, 16'h0401, 8'hBB);
        chk("t4_level2", 32'(fifo_level), 2);
        direct("t4", 8'hE1, 16'h0400, 1'b0, 8'h00);
        slot();
        chk_drain("t4_d0", 17'h00400, 8'hAA);
        chk("t4_stall_d0", 32'(cpu_stall), 1);
        slot();
        chk_drain("t4_d1", 17'h00401, 8'hBB);
        chk("t4_stall_d1", 32'(cpu_stall),  1);
        chk("t4_level0",   32'(fifo_level), 0);
        tick();
        chk("t4_stall_ws", 32'(cpu_stall), 1);
        slot();
        chk("t4_acc_ce",    32'(slow_ce),   1);
        chk("t4_acc_we",    32'(slow_we),   0);
        chk("t4_acc_addr",  32'(slow_addr), 32'h10400);
        chk("t4_acc_stall", 32'(cpu_stall), 1);
        chk("t4_acc_rdv",   32'(rd_valid),  0);
        tick();
        chk("t4_rdv",      32'(rd_valid),  1);
        chk("t4_rdata",    32'(rd_data),   32'h5A);
        chk("t4_released", 32'(cpu_stall), 0);
        chk("t4_ce_off",   32'(slow_ce),   0);
        tick();
        chk("t4_rdv_pulse", 32'(rd_valid), 0);

        // Direct write to E0 with empty buffer
        direct("t4w", 8'hE0, 16'h1234, 1'b1, 8'h77);
        tick();
        slot();
        chk_drain("t4w", 17'h01234, 8'h77);
        tick();
        chk("t4w_rdv",   32'(rd_valid),  1);
        chk("t4w_stall", 32'(cpu_stall), 0);

        // shadow_all extends eligibility to banks below RAMSIZE only
        shadow_all = 1'b1;
        wr(8'h05, 16'h0400, 8'hC3);
        chk("t5_all_hit", 32'(fifo_level), 1);
        slot();
        chk_drain("t5", 17'h10400, 8'hC3);
        wr(8'h14, 16'h0400, 8'hC4);
        chk("t5_ramsize_edge", 32'(fifo_level), 0);
        shadow_all = 1'b0;
        wr(8'h05, 16'h0400, 8'hC5);
        chk("t5_all_off", 32'(fifo_level), 0);

        // Reset in WAIT_SLOT with buffered entries
        direct("t6", 8'hE0, 16'h0000, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 3; i++)
            wr(8'h00, 16'h0400 + 16'(i), 8'h90 + 8'(i));
        chk("t6_level3", 32'(fifo_level), 3);
        chk("t6_stall",  32'(cpu_stall),  1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_stall", 32'(cpu_stall),  0);
        chk("t6_rst_addr",  32'(slow_addr),  0);
        chk("t6_rst_wdata", 32'(slow_wdata), 0);
        chk("t6_rst_rdata", 32'(rd_data),    0);
        chk("t6_rst_ce",    32'(slow_ce),    0);
        tick();
        reset = 1'b0;
        slot();
        chk("t6_slot_ce",    32'(slow_ce),    0);
        chk("t6_slot_level", 32'(fifo_level), 0);
        chk("t6_slot_stall", 32'(cpu_stall),  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
